// File: rtl/hold_until_ack_monitor.sv
// rtl/hold_until_ack_monitor.sv - hold-until-ack protocol monitor with pass/fail reporting
//
// Purpose: checks that once `a` rises it stays high until `b` is asserted,
// and that `b` falls on the following cycle. Each transaction ends in a
// one-cycle pass or fail pulse. The failure code and measured hold length
// are reported alongside saturating pass and fail counters.
//
// Ports:
//   clk        sampling clock, posedge
//   rst_n      asynchronous active-low reset
//   clear      synchronous clear of state and counters
//   a          request being held
//   b          acknowledge
//   busy       transaction open (HOLD or ACK)
//   pass_pulse one-cycle pass strobe
//   fail_pulse one-cycle fail strobe
//   fail_code  last failure: 0 none, 1 early drop, 2 ack stuck, 3 timeout
//   hold_len   sampled-high length of the last transaction
//   pass_cnt   saturating pass count
//   fail_cnt   saturating fail count
module hold_until_ack_monitor #(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             a,
   input  logic             b,
   output logic             busy,
   output logic             pass_pulse,
   output logic             fail_pulse,
   output logic [1:0]       fail_code,
   output logic [CNT_W-1:0] hold_len,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   localparam logic [1:0]       CODE_EARLY   = 2'd1;
   localparam logic [1:0]       CODE_STUCK   = 2'd2;
   localparam logic [1:0]       CODE_TIMEOUT = 2'd3;
   localparam logic [CNT_W-1:0] CNT_MAX      = '1;
   // One extra bit so count+1 can be compared against the limit without wrapping.
   localparam logic [CNT_W:0]   WAIT_LIM     = (CNT_W+1)'(MAX_WAIT);

   state_t           r_state;
   logic             r_a_q;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_hold_len;
   logic [CNT_W-1:0] r_pass_cnt;
   logic [CNT_W-1:0] r_fail_cnt;
   logic [1:0]       r_fail_code;
   logic             r_pass_pulse;
   logic             r_fail_pulse;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_len_nxt;
   logic [1:0]       w_code_nxt;
   logic             w_pass_evt;
   logic             w_fail_evt;
   logic             w_rise;
   logic [CNT_W:0]   w_cnt_inc;

   assign w_rise    = a & ~r_a_q;
   assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_len_nxt   = r_hold_len;
      w_code_nxt  = r_fail_code;
      w_pass_evt  = 1'b0;
      w_fail_evt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Acks outside a transaction are ignored; only a fresh rise opens one.
            if (w_rise) begin
               if (b) begin
                  w_state_nxt = S_ACK;
                  w_len_nxt   = CNT_W'(1);
               end else begin
                  w_state_nxt = S_HOLD;
                  w_cnt_nxt   = CNT_W'(1);
               end
            end
         end
         S_HOLD: begin
            if (!a) begin
               w_fail_evt  = 1'b1;
               w_code_nxt  = CODE_EARLY;
               w_len_nxt   = r_cnt;
               w_state_nxt = S_IDLE;
            end else if (b) begin
               w_len_nxt   = w_cnt_inc[CNT_W-1:0];
               w_state_nxt = S_ACK;
            end else if (w_cnt_inc > WAIT_LIM) begin
               w_fail_evt  = 1'b1;
               w_code_nxt  = CODE_TIMEOUT;
               w_len_nxt   = r_cnt;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt   = w_cnt_inc[CNT_W-1:0];
            end
         end
         S_ACK: begin
            // hold_len was latched on entry; a is ignored here.
            if (b) begin
               w_fail_evt = 1'b1;
               w_code_nxt = CODE_STUCK;
            end else begin
               w_pass_evt = 1'b1;
            end
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (clear) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_a_q   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_a_q   <= a;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_len   <= '0;
         r_pass_cnt   <= '0;
         r_fail_cnt   <= '0;
         r_fail_code  <= 2'd0;
         r_pass_pulse <= 1'b0;
         r_fail_pulse <= 1'b0;
      end else if (clear) begin
         r_hold_len   <= '0;
         r_pass_cnt   <= '0;
         r_fail_cnt   <= '0;
         r_fail_code  <= 2'd0;
         r_pass_pulse <= 1'b0;
         r_fail_pulse <= 1'b0;
      end else begin
         r_hold_len   <= w_len_nxt;
         r_fail_code  <= w_code_nxt;
         r_pass_pulse <= w_pass_evt;
         r_fail_pulse <= w_fail_evt;
         if (w_pass_evt && (r_pass_cnt != CNT_MAX)) begin
            r_pass_cnt <= r_pass_cnt + CNT_W'(1);
         end
         if (w_fail_evt && (r_fail_cnt != CNT_MAX)) begin
            r_fail_cnt <= r_fail_cnt + CNT_W'(1);
         end
      end
   end

   assign busy       = (r_state != S_IDLE);
   assign pass_pulse = r_pass_pulse;
   assign fail_pulse = r_fail_pulse;
   assign fail_code  = r_fail_code;
   assign hold_len   = r_hold_len;
   assign pass_cnt   = r_pass_cnt;
   assign fail_cnt   = r_fail_cnt;

endmodule
